ldpc_wb_sequencer: RTL
======================

LDPC_WB_SEQUENCER -- requirements
Module: ldpc_wb_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000: Wishbone base address of the register window.
REQ-002 SHALL have parameter IN_WORDS, default 8: max 32-bit words fed to the datapath per job (1..8).
REQ-003 SHALL have parameter OUT_WORDS, default 8: max 32-bit result words collected per job (1..8).
REQ-004 SHALL have parameter TIMEOUT, default 16'd4096: max cycles in RUN before abort.
REQ-005 SHALL have ports in this order:
- wb_clk_i  in  1  single clock; all logic on its rising edge
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle/strobe/write
- wbs_sel_i  in  4  byte selects; only 4'hF writes honoured
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- dp_start_o  out  1  one-cycle job start pulse to LDPC datapath
- dp_mode_o  out  1  0 = encode, 1 = decode; held stable from FEED to DONE/ERR
- dp_wdata_o  out  32; dp_wvalid_o  out  1; dp_wready_i  in  1  input stream
- dp_rdata_i  in  32; dp_rvalid_i  in  1; dp_rready_o  out  1  result stream
- dp_done_i  in  1  datapath finished; dp_fail_i  in  1  decode failure, sampled with dp_done_i
- status_o  out  16  progress word for GPIO checkbits
- irq_o  out  1  level interrupt, set on DONE/ERR, cleared by STATUS read

Function
REQ-006 SHALL decode registers at BASE_ADR + 0x00 CTRL (W: bit0 start, bit1 mode, bit2 abort; R: mode), 0x04 STATUS (R: [2:0] state, [3] fail, [4] timeout, [11:8] in count, [15:12] out count), 0x08 IN_DATA (W: push input buffer), 0x0C OUT_DATA (R: pop result buffer), 0x10 LEN (W/R: [3:0] in_len, [7:4] out_len).
REQ-007 SHALL assert wbs_ack_o exactly one cycle, the cycle after cyc&stb with ack low; back-to-back accesses therefore take 2 cycles each; unmapped addresses ack with read data 0.
REQ-008 SHALL hold an 8x32 input buffer and 8x32 result buffer with 4-bit counts; IN_DATA write when in count = IN_WORDS is dropped and sets STATUS[4]-independent sticky ovf, reported as STATUS[5]; OUT_DATA read when empty returns 32'h0 and does not underflow.
REQ-009 SHALL implement FSM IDLE(0) -> FEED(1) -> RUN(2) -> COLLECT(3) -> DONE(4), plus ERR(5).
REQ-010 IDLE: CTRL write with start=1 and in count = in_len (nonzero) -> FEED, latch mode, pulse dp_start_o, status_o = 16'hAB60; start otherwise ignored.
REQ-011 FEED: dp_wvalid_o high with buffer head; word consumed when dp_wvalid_o & dp_wready_i; after in_len words -> RUN, dp_wvalid_o low.
REQ-012 RUN: timeout counter increments each cycle; dp_done_i -> COLLECT, latch dp_fail_i; counter reaching TIMEOUT first -> ERR with STATUS[4]=1.
REQ-013 COLLECT: dp_rready_o high; each dp_rvalid_i & dp_rready_o pushes dp_rdata_i; after out_len words -> DONE.
REQ-014 DONE: status_o = {14'h3FFD, ~fail, 1'b0} (16'hFFF6 pass, 16'hFFF4 fail); ERR: status_o = 16'hDEAD; both set irq_o; next start write -> FEED with buffers' old results cleared.
REQ-015 CTRL abort=1 in any state SHALL return to IDLE next cycle, flush both buffers, deassert all dp_* strobes, status_o = 16'h0000; abort wins over simultaneous start.
REQ-016 IN_DATA writes outside IDLE/DONE/ERR SHALL be dropped; simultaneous OUT_DATA pop and COLLECT push SHALL not occur (reads return 0 outside DONE).

Reset
REQ-017 On wb_rst_n_i low, asynchronously: state IDLE, counts 0, flags 0, wbs_ack_o, wbs_dat_o, dp_start_o, dp_mode_o, dp_wvalid_o, dp_rready_o, irq_o = 0, dp_wdata_o = 0, status_o = 16'h0000; reset mid-job discards the job.

Verification
REQ-018 Encode: LEN=0x84, push 4 words, start mode 0, model returns 8 words, done fail=0 -> status_o 16'hAB60 then 16'hFFF6, 8 OUT_DATA reads match, irq_o set then cleared by STATUS read.
REQ-019 Decode fail: mode 1, dp_fail_i=1 with dp_done_i -> status_o 16'hFFF4, STATUS[3]=1.
REQ-020 Backpressure: dp_wready_i toggled every other cycle, dp_rvalid_i bursty -> no word lost or duplicated, order preserved.
REQ-021 Timeout: dp_done_i never asserted -> ERR after exactly TIMEOUT cycles in RUN, status_o 16'hDEAD, STATUS[4]=1.
REQ-022 Overflow/abort: 9 IN_DATA writes -> 9th dropped, STATUS[5]=1; abort during COLLECT -> IDLE, counts 0, status_o 16'h0000.
REQ-023 Reset mid-FEED: wb_rst_n_i pulsed low -> all outputs at reset values same cycle, new job then completes normally.

Source files
------------

// File: rtl/ldpc_wb_sequencer_if.sv
// Wishbone classic slave bus bundle for the LDPC job sequencer.
// Master drives cycle/strobe/address/data, slave returns ack and read data.
interface ldpc_wb_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;

  modport master (
    output cyc, stb, we, sel, adr, wdat,
    input  ack, rdat
  );

  modport slave (
    input  cyc, stb, we, sel, adr, wdat,
    output ack, rdat
  );
endinterface

// File: rtl/ldpc_wb_sequencer.sv
// Wishbone-controlled job sequencer for an LDPC encode/decode datapath.
// Buffers input words, streams them out, collects results, reports status.
module ldpc_wb_sequencer #(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter int          IN_WORDS  = 8,
  parameter int          OUT_WORDS = 8,
  parameter logic [15:0] TIMEOUT   = 16'd4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        dp_start_o,
  output logic        dp_mode_o,
  output logic [31:0] dp_wdata_o,
  output logic        dp_wvalid_o,
  input  logic        dp_wready_i,
  input  logic [31:0] dp_rdata_i,
  input  logic        dp_rvalid_i,
  output logic        dp_rready_o,
  input  logic        dp_done_i,
  input  logic        dp_fail_i,
  output logic [15:0] status_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FEED = 3'd1,
    S_RUN  = 3'd2,
    S_COLL = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] IN_MAX  = 4'(IN_WORDS);
  localparam logic [3:0] OUT_MAX = 4'(OUT_WORDS);

  state_t state, state_nx;

  logic [31:0] in_buf  [8];
  logic [31:0] out_buf [8];
  logic [3:0]  in_cnt, out_cnt, in_len, out_len;
  logic [3:0]  fptr, rptr, olen;
  logic [15:0] tcnt;
  logic        mode, fail, tmo, ovf;

  logic [31:0] off, rdata;
  logic [2:0]  reg_ix;
  logic        acc, hit, wr, rd;
  logic        wr_ctrl, wr_in, wr_len, rd_stat, rd_out;
  logic        abort, start, ld_ok, go;
  logic        wfire, rfire, pop, push_in, push_out;

  assign off    = wbs_adr_i - BASE_ADR;
  assign reg_ix = off[4:2];
  assign acc    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign hit    = (off[31:5] == 27'd0) && (off[1:0] == 2'd0)
               && (reg_ix <= 3'd4);
  assign wr     = acc & wbs_we_i & (wbs_sel_i == 4'hF) & hit;
  assign rd     = acc & ~wbs_we_i & hit;

  assign wr_ctrl = wr & (reg_ix == 3'd0);
  assign wr_in   = wr & (reg_ix == 3'd2);
  assign wr_len  = wr & (reg_ix == 3'd4);
  assign rd_stat = rd & (reg_ix == 3'd1);
  assign rd_out  = rd & (reg_ix == 3'd3);

  assign abort = wr_ctrl & wbs_dat_i[2];
  assign start = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[2];
  assign ld_ok = state inside {S_IDLE, S_DONE, S_ERR};
  assign go    = start & ld_ok & (in_len != 4'd0) & (in_cnt == in_len);

  assign olen  = (out_len > OUT_MAX) ? OUT_MAX : out_len;
  assign wfire = dp_wvalid_o & dp_wready_i;
  assign rfire = dp_rvalid_i & dp_rready_o;
  assign pop   = rd_out & (state == S_DONE) & (out_cnt != 4'd0);

  assign push_in  = wr_in & ld_ok & (in_cnt < IN_MAX);
  assign push_out = (state == S_COLL) & rfire & (out_cnt < olen);

  assign dp_mode_o = mode;

  // Job state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= S_IDLE;
    else             state <= state_nx;
  end

  // Job sequencing; abort overrides every state.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR:
          if (go) state_nx = S_FEED;
        S_FEED:
          if (wfire && (fptr + 4'd1 == in_len)) state_nx = S_RUN;
        S_RUN:
          if (dp_done_i)                     state_nx = S_COLL;
          else if (tcnt == TIMEOUT - 16'd1) state_nx = S_ERR;
        S_COLL:
          if ((olen == 4'd0) ||
              (rfire && (out_cnt + 4'd1 == olen)))
            state_nx = S_DONE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Datapath strobes and progress word follow the current state.
  always_comb begin
    dp_wvalid_o = 1'b0;
    dp_rready_o = 1'b0;
    dp_wdata_o  = 32'h0;
    status_o    = 16'h0000;
    unique case (state)
      S_FEED: begin
        dp_wvalid_o = 1'b1;
        dp_wdata_o  = in_buf[fptr[2:0]];
        status_o    = 16'hAB60;
      end
      S_RUN:  status_o = 16'hAB60;
      S_COLL: begin
        dp_rready_o = (olen != 4'd0);
        status_o    = 16'hAB60;
      end
      S_DONE: status_o = {14'h3FFD, ~fail, 1'b0};
      S_ERR:  status_o = 16'hDEAD;
      default: ;
    endcase
  end

  // Register read mux; OUT_DATA yields data only on a real pop.
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      unique case (reg_ix)
        3'd0: rdata = {31'h0, mode};
        3'd1: rdata = {16'h0, out_cnt, in_cnt, 2'b00,
                       ovf, tmo, fail, state};
        3'd3: if (pop) rdata = out_buf[rptr[2:0]];
        3'd4: rdata = {24'h0, out_len, in_len};
        default: ;
      endcase
    end
  end

  // Wishbone ack/data: one-cycle ack after each new access.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= acc;
      if (acc && !wbs_we_i) wbs_dat_o <= rdata;
    end
  end

  // Buffer storage; contents are qualified by the counts.
  always_ff @(posedge wb_clk_i) begin
    if (push_in)  in_buf[in_cnt[2:0]]   <= wbs_dat_i;
    if (push_out) out_buf[out_cnt[2:0]] <= dp_rdata_i;
  end

  // Counts, pointers, flags, start pulse and interrupt.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      in_cnt     <= 4'd0;
      out_cnt    <= 4'd0;
      in_len     <= 4'd0;
      out_len    <= 4'd0;
      fptr       <= 4'd0;
      rptr       <= 4'd0;
      tcnt       <= 16'd0;
      mode       <= 1'b0;
      fail       <= 1'b0;
      tmo        <= 1'b0;
      ovf        <= 1'b0;
      irq_o      <= 1'b0;
      dp_start_o <= 1'b0;
    end else begin
      dp_start_o <= go;
      if (abort) begin
        in_cnt  <= 4'd0;
        out_cnt <= 4'd0;
        fptr    <= 4'd0;
        rptr    <= 4'd0;
        tcnt    <= 16'd0;
        fail    <= 1'b0;
        tmo     <= 1'b0;
        ovf     <= 1'b0;
        irq_o   <= 1'b0;
      end else begin
        if (go) begin
          mode    <= wbs_dat_i[1];
          fptr    <= 4'd0;
          rptr    <= 4'd0;
          out_cnt <= 4'd0;
          tcnt    <= 16'd0;
          fail    <= 1'b0;
          tmo     <= 1'b0;
        end
        if (push_in) in_cnt <= in_cnt + 4'd1;
        else if (wr_in && ld_ok) ovf <= 1'b1;
        if (wr_len && ld_ok) begin
          in_len  <= wbs_dat_i[3:0];
          out_len <= wbs_dat_i[7:4];
        end
        if (state == S_FEED && wfire) begin
          fptr   <= fptr + 4'd1;
          in_cnt <= in_cnt - 4'd1;
        end
        if (state == S_RUN) begin
          tcnt <= tcnt + 16'd1;
          if (dp_done_i) fail <= dp_fail_i;
          else if (tcnt == TIMEOUT - 16'd1) tmo <= 1'b1;
        end
        if (push_out) out_cnt <= out_cnt + 4'd1;
        if (pop) begin
          rptr    <= rptr + 4'd1;
          out_cnt <= out_cnt - 4'd1;
        end
        if ((state_nx == S_DONE && state != S_DONE) ||
            (state_nx == S_ERR && state != S_ERR))
          irq_o <= 1'b1;
        else if (rd_stat || go)
          irq_o <= 1'b0;
      end
    end
  end

endmodule
